// File: rtl/chi_req_link_tx_if.sv
// ============================================================================
//  chi_req_pkg / chi_hn_req_intf
//  REQ flit type and the REQ-channel link signals between a requester and an HN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package chi_req_pkg;
  parameter int REQFLIT_W = 64;
  typedef logic [REQFLIT_W-1:0] reqflit_t;
endpackage

interface chi_hn_req_intf;
  import chi_req_pkg::*;

  logic     flitpend;
  logic     flitv;
  reqflit_t flit;
  logic     lcrdv;

  modport TX (output flitpend, output flitv, output flit, input lcrdv);
  modport RX (input flitpend, input flitv, input flit, output lcrdv);
endinterface

`default_nettype wire

// File: rtl/chi_req_link_tx.sv
// ============================================================================
//  chi_req_link_tx
//  CHI REQ link-layer transmitter: flit buffer, L-credit accounting and a
//  STOP/RUN/DRAIN link state machine; flitpend leads flitv by one cycle.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module chi_req_link_tx
  import chi_req_pkg::*;
#(
  parameter int MAX_CRD    = 15,
  parameter int FIFO_DEPTH = 2,
  localparam int CW        = $clog2(MAX_CRD + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          link_en_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  reqflit_t      in_flit_i,
  chi_hn_req_intf.TX    tx,
  output logic [CW-1:0] crd_cnt_o,
  output logic          link_idle_o,
  output logic          crd_err_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] c_st_stop  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;

  localparam logic [CW-1:0] c_max_crd  = CW'(MAX_CRD);
  localparam logic [PW-1:0] c_ptr_last = PW'(FIFO_DEPTH - 1);
  localparam logic [OW-1:0] c_depth    = OW'(FIFO_DEPTH);

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [CW-1:0] crd_q, crd_d;
  logic          err_q, err_d;
  logic          flitv_q, flitv_d;
  reqflit_t      flit_q, flit_d;
  reqflit_t      mem_q [FIFO_DEPTH];

  logic w_send;
  logic w_push;
  logic w_fifo_empty;
  logic w_fifo_full;
  logic w_to_stop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == c_ptr_last) ? '0 : p + PW'(1);
  endfunction

  assign w_fifo_empty = (occ_q == '0);
  assign w_fifo_full  = (occ_q == c_depth);
  assign w_push       = in_valid_i && in_ready_o;

  // Link state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_st_stop;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_stop:  if (link_en_i) state_d = c_st_run;
      c_st_run:   if (!link_en_i) state_d = c_st_drain;
      c_st_drain: begin
        if (link_en_i) begin
          state_d = c_st_run;
        end else if (w_fifo_empty && !flitv_q) begin
          state_d = c_st_stop;
        end
      end
      default:    state_d = c_st_stop;
    endcase
  end

  // Send uses registered state only, so flitpend has no input-to-output path
  always_comb begin
    in_ready_o  = (state_q == c_st_run) && !w_fifo_full;
    link_idle_o = (state_q == c_st_stop);
    w_send      = (state_q != c_st_stop) && !w_fifo_empty && (crd_q != '0);
  end

  assign w_to_stop = (state_q == c_st_drain) && (state_d == c_st_stop);

  always_comb begin
    crd_d = crd_q;
    err_d = err_q;
    if (state_q == c_st_stop) begin
      if (tx.lcrdv) err_d = 1'b1;
    end else if (tx.lcrdv && !w_send) begin
      if (crd_q == c_max_crd) begin
        err_d = 1'b1;
      end else begin
        crd_d = crd_q + CW'(1);
      end
    end else if (!tx.lcrdv && w_send) begin
      crd_d = crd_q - CW'(1);
    end
    if (w_to_stop) crd_d = '0;
  end

  always_comb begin
    wr_ptr_d = w_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = w_send ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    occ_d    = occ_q;
    case ({w_push, w_send})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
    flitv_d = w_send;
    flit_d  = w_send ? mem_q[rd_ptr_q] : flit_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      crd_q    <= '0;
      err_q    <= 1'b0;
      flitv_q  <= 1'b0;
      flit_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      crd_q    <= crd_d;
      err_q    <= err_d;
      flitv_q  <= flitv_d;
      flit_q   <= flit_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= in_flit_i;
  end

  assign tx.flitpend = w_send;
  assign tx.flitv    = flitv_q;
  assign tx.flit     = flit_q;
  assign crd_cnt_o   = crd_q;
  assign crd_err_o   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_chi_req_link_tx.sv
// ============================================================================
//  tb_chi_req_link_tx
//  Directed and randomized bench for chi_req_link_tx with a scoreboard.
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_chi_req_link_tx;
  import chi_req_pkg::*;

  localparam int MAXC  = 15;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       link_en;
  logic       in_valid;
  logic       lcrdv;
  reqflit_t   in_flit;
  logic       in_ready;
  logic       link_idle;
  logic       crd_err;
  logic [3:0] crd_cnt;

  always #5 clk = ~clk;

  chi_hn_req_intf txi();
  assign txi.lcrdv = lcrdv;

  chi_req_link_tx #(.MAX_CRD(MAXC), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .link_en_i  (link_en),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_flit_i  (in_flit),
    .tx         (txi),
    .crd_cnt_o  (crd_cnt),
    .link_idle_o(link_idle),
    .crd_err_o  (crd_err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: link mode, buffered-flit count and credit balance
  typedef enum int {M_STOP, M_RUN, M_DRAIN} mstate_e;
  mstate_e  m_state = M_STOP;
  mstate_e  m_nxt;
  int       m_occ   = 0;
  int       m_crd   = 0;
  bit       m_err   = 1'b0;
  bit       m_flitv = 1'b0;
  bit       m_snd, m_acc, exp_pend;
  reqflit_t sb[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = M_STOP; m_occ = 0; m_crd = 0; m_err = 1'b0; m_flitv = 1'b0;
      sb.delete();
    end else begin
      m_snd = (m_state != M_STOP) && (m_occ > 0) && (m_crd > 0);
      m_acc = in_valid && (m_state == M_RUN) && (m_occ < DEPTH);
      if (m_acc) sb.push_back(in_flit);
      if (m_state == M_STOP) begin
        if (lcrdv) m_err = 1'b1;
      end else begin
        m_crd = m_crd + int'(lcrdv) - int'(m_snd);
        if (m_crd > MAXC) begin
          m_crd = MAXC;
          m_err = 1'b1;
        end
      end
      m_nxt = m_state;
      case (m_state)
        M_STOP:  if (link_en) m_nxt = M_RUN;
        M_RUN:   if (!link_en) m_nxt = M_DRAIN;
        default: begin
          if (link_en) m_nxt = M_RUN;
          else if (m_occ == 0 && !m_flitv) begin
            m_nxt = M_STOP;
            m_crd = 0;
          end
        end
      endcase
      m_occ   = m_occ + int'(m_acc) - int'(m_snd);
      m_flitv = m_snd;
      m_state = m_nxt;
    end
  end

  // Monitor: compare outputs to the model and pop the scoreboard on flitv
  always @(negedge clk) begin
    exp_pend = (m_state != M_STOP) && (m_occ > 0) && (m_crd > 0);
    chk("flitpend", txi.flitpend, exp_pend);
    chk("flitv", txi.flitv, m_flitv);
    chk("in_ready", in_ready, (m_state == M_RUN) && (m_occ < DEPTH));
    chk("crd_cnt", crd_cnt, m_crd);
    chk("link_idle", link_idle, m_state == M_STOP);
    chk("crd_err", crd_err, m_err);
    if (txi.flitv === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL flit_order: got flit %0h expected no flit at %0t", txi.flit, $time);
      end else begin
        chk("flit", txi.flit, sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  int pend_n, v_n, guard;

  initial begin
    rst_n = 1'b0; link_en = 1'b0; in_valid = 1'b0; lcrdv = 1'b0; in_flit = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_idle", link_idle, 1'b1);
    chk("rst_crd", crd_cnt, 4'd0);
    chk("rst_ready", in_ready, 1'b0);

    // Single send: one credit, one flit
    link_en = 1'b1; step();
    lcrdv = 1'b1; step(); lcrdv = 1'b0;
    in_valid = 1'b1; in_flit = 64'hA; step(); in_valid = 1'b0;
    chk("t2_pend_c1", txi.flitpend, 1'b1);
    chk("t2_v_c1", txi.flitv, 1'b0);
    step();
    chk("t2_v_c2", txi.flitv, 1'b1);
    chk("t2_flit", txi.flit, 64'hA);
    chk("t2_crd", crd_cnt, 4'd0);

    // No credit: buffer fills and stalls
    in_valid = 1'b1; in_flit = 64'hB; step();
    in_flit = 64'hC; step(); in_valid = 1'b0;
    chk("t3_ready", in_ready, 1'b0);
    chk("t3_pend", txi.flitpend, 1'b0);
    lcrdv = 1'b1; step(); lcrdv = 1'b0;
    chk("t3_pend_crd", txi.flitpend, 1'b1);
    step();
    chk("t3_flit", txi.flit, 64'hB);
    chk("t3_stall", txi.flitpend, 1'b0);
    step();
    chk("t3_v_off", txi.flitv, 1'b0);
    lcrdv = 1'b1; step(); lcrdv = 1'b0;
    repeat (2) step();

    // Back-to-back stream of four flits with four credits
    lcrdv = 1'b1; repeat (4) step(); lcrdv = 1'b0;
    chk("t4_crd4", crd_cnt, 4'd4);
    pend_n = 0; v_n = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_flit = 64'hD0 + 64'(i); step();
      pend_n += int'(txi.flitpend); v_n += int'(txi.flitv);
    end
    in_valid = 1'b0;
    repeat (3) begin
      step();
      pend_n += int'(txi.flitpend); v_n += int'(txi.flitv);
    end
    chk("t4_pend_cycles", pend_n, 4);
    chk("t4_v_cycles", v_n, 4);
    chk("t4_crd0", crd_cnt, 4'd0);

    // Credit return coinciding with a send, then overflow
    lcrdv = 1'b1; step();
    in_valid = 1'b1; in_flit = 64'hE; step(); in_valid = 1'b0;
    chk("t5_crd_pre", crd_cnt, 4'd2);
    step();
    chk("t5_crd_same", crd_cnt, 4'd2);
    repeat (16) step();
    lcrdv = 1'b0;
    chk("t5_sat", crd_cnt, 4'd15);
    chk("t5_err", crd_err, 1'b1);

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_flit = 64'hF0 + 64'(i); step();
    end
    chk("t1_v_before", txi.flitv, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_flitv", txi.flitv, 1'b0);
    chk("t1_pend", txi.flitpend, 1'b0);
    chk("t1_crd", crd_cnt, 4'd0);
    chk("t1_ready", in_ready, 1'b0);
    in_valid = 1'b0; link_en = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("t1_idle", link_idle, 1'b1);
    chk("t1_err_clr", crd_err, 1'b0);

    // Drain: two buffered flits, one credit, then a late credit
    link_en = 1'b1; step();
    chk("t1_ready_run", in_ready, 1'b1);
    in_valid = 1'b1; in_flit = 64'h51; step();
    in_flit = 64'h52; step(); in_valid = 1'b0;
    chk("t6_full", in_ready, 1'b0);
    link_en = 1'b0; lcrdv = 1'b1; step(); lcrdv = 1'b0;
    chk("t6_drain", link_idle, 1'b0);
    chk("t6_pend", txi.flitpend, 1'b1);
    step();
    chk("t6_flit1", txi.flit, 64'h51);
    repeat (3) step();
    chk("t6_wait", link_idle, 1'b0);
    chk("t6_wait_pend", txi.flitpend, 1'b0);
    lcrdv = 1'b1; step(); lcrdv = 1'b0;
    step();
    chk("t6_flit2", txi.flit, 64'h52);
    repeat (3) step();
    chk("t6_stop", link_idle, 1'b1);
    chk("t6_crd", crd_cnt, 4'd0);

    // Randomized traffic
    link_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) link_en = ~link_en;
      in_valid = 1'($urandom_range(0, 1));
      in_flit  = {$urandom, $urandom};
      lcrdv    = ($urandom_range(0, 9) < 4);
      if (i == 1500) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      step();
    end

    // Flush everything still expected
    link_en = 1'b1; in_valid = 1'b0; lcrdv = 1'b1;
    guard = 0;
    while ((sb.size() != 0 || txi.flitv === 1'b1) && guard < 300) begin
      step();
      guard++;
    end
    lcrdv = 1'b0;
    if (guard >= 300) begin
      n_chk++;
      n_err++;
      $display("FAIL flush_timeout: got %0d pending expected 0", sb.size());
    end
    step();
    chk("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
